// File: rtl/acumulador_multicanal_pkg.sv
// Shared types and helpers for the multichannel accumulator: FSM state encoding
// and the clog2 helper used to size the channel index.
package acumulador_multicanal_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/acumulador_multicanal_if.sv
// Request/response bundle of the multichannel accumulator.
// Requests (load, transf, ch_clr) are single-cycle pulses with no ready signal:
// busy high means any request is dropped and err pulses the following cycle;
// out_valid pulses for one cycle when out/carry hold a freshly transferred value.
interface acumulador_multicanal_if
  import acumulador_multicanal_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int CH_BITS = clog2(CHANNELS);

  logic               load;
  logic               transf;
  logic               ch_clr;
  logic               sat_mode;
  logic [CH_BITS-1:0] ch_sel;
  logic [WIDTH-1:0]   in;
  logic [WIDTH-1:0]   out;
  logic               carry;
  logic               out_valid;
  logic               busy;
  logic               err;
  state_t             state;

  modport master (
    output load, transf, ch_clr, sat_mode, ch_sel, in,
    input  out, carry, out_valid, busy, err, state
  );

  modport slave (
    input  load, transf, ch_clr, sat_mode, ch_sel, in,
    output out, carry, out_valid, busy, err, state
  );

endinterface

// File: rtl/acumulador_multicanal_soma_sat.sv
// Shared combinational adder: WIDTH-bit unsigned sum with carry out and an
// optional clamp to all-ones on overflow.
module acc_soma_sat #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    cout = sum[WIDTH];
    res  = (sat && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/acumulador_multicanal.sv
// CHANNELS independent unsigned accumulators sharing one adder; a load takes two
// cycles (IDLE capture, ADD writeback), transfers and channel clears take one.
module acumulador_multicanal
  import acumulador_multicanal_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input logic                     clk,
  input logic                     clear,
  acumulador_multicanal_if.slave  bus
);

  localparam int CH_BITS = clog2(CHANNELS);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   acc [CHANNELS];
  logic [CHANNELS-1:0] flag;

  logic [WIDTH-1:0]   op_q;
  logic [CH_BITS-1:0] op_ch_q;
  logic               op_sat_q;

  logic [WIDTH-1:0]   out_q;
  logic               carry_q;
  logic               out_valid_q;
  logic               err_q;

  logic               any_req, ch_ok;
  logic               do_clr, do_load, do_xfer, do_add, err_d;
  logic [WIDTH-1:0]   add_a, sum_res, rd_acc;
  logic               rd_flag, sum_cout;

  // Channel muxes: the adder reads the captured channel, transfers read ch_sel.
  always_comb begin
    add_a   = '0;
    rd_acc  = '0;
    rd_flag = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (op_ch_q == CH_BITS'(i)) add_a = acc[i];
      if (bus.ch_sel == CH_BITS'(i)) begin
        rd_acc  = acc[i];
        rd_flag = flag[i];
      end
    end
  end

  acc_soma_sat #(.WIDTH(WIDTH)) u_soma (
    .a    (add_a),
    .b    (op_q),
    .sat  (op_sat_q),
    .res  (sum_res),
    .cout (sum_cout)
  );

  always_ff @(posedge clk) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Illegal channel beats everything; ch_clr beats load/transf without an error.
  always_comb begin
    state_d = state_q;
    do_clr  = 1'b0;
    do_load = 1'b0;
    do_xfer = 1'b0;
    do_add  = 1'b0;
    err_d   = 1'b0;
    any_req = bus.load || bus.transf || bus.ch_clr;
    ch_ok   = int'(bus.ch_sel) < CHANNELS;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          if (!ch_ok)                        err_d = 1'b1;
          else if (bus.ch_clr)               do_clr = 1'b1;
          else if (bus.load && bus.transf)   err_d = 1'b1;
          else if (bus.load) begin
            do_load = 1'b1;
            state_d = ST_ADD;
          end
          else                               do_xfer = 1'b1;
        end
      end
      ST_ADD: begin
        do_add  = 1'b1;
        err_d   = any_req;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      flag        <= '0;
      op_q        <= '0;
      op_ch_q     <= '0;
      op_sat_q    <= 1'b0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= do_xfer;
      err_q       <= err_d;
      if (do_load) begin
        op_q     <= bus.in;
        op_ch_q  <= bus.ch_sel;
        op_sat_q <= bus.sat_mode;
      end
      if (do_xfer) begin
        out_q   <= rd_acc;
        carry_q <= rd_flag;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (do_clr && bus.ch_sel == CH_BITS'(i)) begin
          acc[i]  <= '0;
          flag[i] <= 1'b0;
        end else if (do_add && op_ch_q == CH_BITS'(i)) begin
          acc[i] <= sum_res;
          if (sum_cout) flag[i] <= 1'b1;
        end else if (do_xfer && bus.ch_sel == CH_BITS'(i)) begin
          flag[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ST_ADD);
  assign bus.err       = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_acumulador_multicanal.sv
// Directed bench for acumulador_multicanal: a vector table for the main
// operations plus hand sequences for busy, clear mid-op and a 3-channel build.
module tb_acumulador_multicanal;
  import acumulador_multicanal_pkg::*;

  logic clk;
  logic clear;

  acumulador_multicanal_if #(.WIDTH(16), .CHANNELS(4)) b4 ();
  acumulador_multicanal_if #(.WIDTH(16), .CHANNELS(3)) b3 ();

  acumulador_multicanal #(.WIDTH(16), .CHANNELS(4)) dut4 (
    .clk   (clk),
    .clear (clear),
    .bus   (b4.slave)
  );

  acumulador_multicanal #(.WIDTH(16), .CHANNELS(3)) dut3 (
    .clk   (clk),
    .clear (clear),
    .bus   (b3.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers: one-cycle request, returns 1 time unit after the accepting edge
  task automatic pulse4(input logic l, input logic t, input logic c, input logic s,
                        input logic [1:0] ch, input logic [15:0] v);
    b4.load = l; b4.transf = t; b4.ch_clr = c; b4.sat_mode = s;
    b4.ch_sel = ch; b4.in = v;
    @(posedge clk); #1;
    b4.load = 1'b0; b4.transf = 1'b0; b4.ch_clr = 1'b0; b4.sat_mode = 1'b0;
    b4.in = '0;
  endtask

  task automatic pulse3(input logic l, input logic t, input logic [1:0] ch,
                        input logic [15:0] v);
    b3.load = l; b3.transf = t; b3.ch_clr = 1'b0; b3.sat_mode = 1'b0;
    b3.ch_sel = ch; b3.in = v;
    @(posedge clk); #1;
    b3.load = 1'b0; b3.transf = 1'b0; b3.in = '0;
  endtask

  // scoreboard: each observed out_valid consumes the oldest expected value
  task automatic xfer4(input string name, input logic [1:0] ch, input logic exp_carry);
    pulse4(1'b0, 1'b1, 1'b0, 1'b0, ch, 16'h0);
    check({name, ".out_valid"}, 32'(b4.out_valid), 32'd1);
    if (b4.out_valid && exp_q.size() > 0)
      check({name, ".out"}, 32'(b4.out), 32'(exp_q.pop_front()));
    check({name, ".carry"}, 32'(b4.carry), 32'(exp_carry));
  endtask

  task automatic load4(input logic [1:0] ch, input logic s, input logic [15:0] v);
    pulse4(1'b1, 1'b0, 1'b0, s, ch, v);
    check("load.busy", 32'(b4.busy), 32'd1);
    @(posedge clk); #1;
    check("load.busy_done", 32'(b4.busy), 32'd0);
  endtask

  typedef enum {K_LOAD, K_XFER, K_CLR, K_BOTH, K_CLRLOAD} kind_t;
  typedef struct {
    kind_t       kind;
    logic [1:0]  ch;
    logic        sat;
    logic [15:0] val;
    logic [15:0] exp_out;
    logic        exp_carry;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    clear = 1'b1;
    b4.load = 1'b0; b4.transf = 1'b0; b4.ch_clr = 1'b0; b4.sat_mode = 1'b0;
    b4.ch_sel = '0; b4.in = '0;
    b3.load = 1'b0; b3.transf = 1'b0; b3.ch_clr = 1'b0; b3.sat_mode = 1'b0;
    b3.ch_sel = '0; b3.in = '0;

    vecs[0]  = '{K_LOAD,    2'd0, 1'b0, 16'd100,  16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{K_LOAD,    2'd0, 1'b0, 16'd23,   16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{K_XFER,    2'd0, 1'b0, 16'd0,    16'd123,  1'b0, 1'b0};
    vecs[3]  = '{K_LOAD,    2'd1, 1'b0, 16'hFFF0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{K_LOAD,    2'd1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{K_XFER,    2'd1, 1'b0, 16'd0,    16'h0010, 1'b1, 1'b0};
    vecs[6]  = '{K_XFER,    2'd1, 1'b0, 16'd0,    16'h0010, 1'b0, 1'b0};
    vecs[7]  = '{K_LOAD,    2'd2, 1'b1, 16'hFFF0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{K_LOAD,    2'd2, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{K_XFER,    2'd2, 1'b0, 16'd0,    16'hFFFF, 1'b1, 1'b0};
    vecs[10] = '{K_LOAD,    2'd0, 1'b0, 16'd5,    16'h0000, 1'b0, 1'b0};
    vecs[11] = '{K_LOAD,    2'd3, 1'b0, 16'd7,    16'h0000, 1'b0, 1'b0};
    vecs[12] = '{K_CLR,     2'd0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0};
    vecs[13] = '{K_XFER,    2'd0, 1'b0, 16'd0,    16'd0,    1'b0, 1'b0};
    vecs[14] = '{K_XFER,    2'd3, 1'b0, 16'd0,    16'd7,    1'b0, 1'b0};
    vecs[15] = '{K_BOTH,    2'd3, 1'b0, 16'd9,    16'h0000, 1'b0, 1'b1};
    vecs[16] = '{K_XFER,    2'd3, 1'b0, 16'd0,    16'd7,    1'b0, 1'b0};
    vecs[17] = '{K_XFER,    2'd1, 1'b0, 16'd0,    16'h0010, 1'b0, 1'b0};
    vecs[18] = '{K_CLRLOAD, 2'd2, 1'b0, 16'd3,    16'h0000, 1'b0, 1'b0};
    vecs[19] = '{K_XFER,    2'd2, 1'b0, 16'd0,    16'd0,    1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    check("rst.out",       32'(b4.out),       32'd0);
    check("rst.carry",     32'(b4.carry),     32'd0);
    check("rst.out_valid", 32'(b4.out_valid), 32'd0);
    check("rst.busy",      32'(b4.busy),      32'd0);
    check("rst.err",       32'(b4.err),       32'd0);
    check("rst.state",     32'(b4.state),     32'(ST_IDLE));

    for (int i = 0; i < 20; i++) begin
      case (vecs[i].kind)
        K_LOAD: begin
          load4(vecs[i].ch, vecs[i].sat, vecs[i].val);
        end
        K_XFER: begin
          exp_q.push_back(vecs[i].exp_out);
          xfer4($sformatf("vec%0d", i), vecs[i].ch, vecs[i].exp_carry);
        end
        K_CLR: begin
          pulse4(1'b0, 1'b0, 1'b1, 1'b0, vecs[i].ch, 16'h0);
          check($sformatf("vec%0d.busy", i), 32'(b4.busy), 32'd0);
        end
        K_BOTH: begin
          pulse4(1'b1, 1'b1, 1'b0, 1'b0, vecs[i].ch, vecs[i].val);
          check($sformatf("vec%0d.busy", i), 32'(b4.busy), 32'd0);
        end
        default: begin
          pulse4(1'b1, 1'b0, 1'b1, 1'b0, vecs[i].ch, vecs[i].val);
          check($sformatf("vec%0d.busy", i), 32'(b4.busy), 32'd0);
        end
      endcase
      if (vecs[i].kind != K_LOAD)
        check($sformatf("vec%0d.err", i), 32'(b4.err), 32'(vecs[i].exp_err));
    end

    // out_valid lasts one cycle and out/carry hold afterwards
    @(posedge clk); #1;
    check("hold.out_valid", 32'(b4.out_valid), 32'd0);
    check("hold.out",       32'(b4.out),       32'd0);

    // load during ADD is dropped with err; ch3 = 7 + 1 = 8
    pulse4(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 16'd1);
    check("busy.state", 32'(b4.state), 32'(ST_ADD));
    pulse4(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 16'd100);
    check("busy.err",  32'(b4.err),  32'd1);
    check("busy.busy", 32'(b4.busy), 32'd0);
    @(posedge clk); #1;
    check("busy.err_pulse", 32'(b4.err), 32'd0);

    // back-to-back transfers keep out_valid high
    exp_q.push_back(16'd8);
    xfer4("b2b0", 2'd3, 1'b0);
    exp_q.push_back(16'h0010);
    xfer4("b2b1", 2'd1, 1'b0);

    // clear in the ADD cycle discards the operand and wipes every channel
    pulse4(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd50);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("midclr.busy", 32'(b4.busy), 32'd0);
    check("midclr.out",  32'(b4.out),  32'd0);
    exp_q.push_back(16'd0);
    xfer4("midclr.ch0", 2'd0, 1'b0);
    exp_q.push_back(16'd0);
    xfer4("midclr.ch3", 2'd3, 1'b0);

    // 3-channel build: ch_sel = 3 is illegal
    pulse3(1'b1, 1'b0, 2'd3, 16'd9);
    check("ch3.err",  32'(b3.err),  32'd1);
    check("ch3.busy", 32'(b3.busy), 32'd0);
    pulse3(1'b1, 1'b0, 2'd2, 16'd9);
    check("ch3.legal_busy", 32'(b3.busy), 32'd1);
    check("ch3.legal_err",  32'(b3.err),  32'd0);
    @(posedge clk); #1;
    pulse3(1'b0, 1'b1, 2'd2, 16'd0);
    check("ch3.out_valid", 32'(b3.out_valid), 32'd1);
    check("ch3.out",       32'(b3.out),       32'd9);
    pulse3(1'b0, 1'b1, 2'd3, 16'd0);
    check("ch3.xfer_err",  32'(b3.err),       32'd1);
    check("ch3.xfer_ov",   32'(b3.out_valid), 32'd0);
    check("ch3.out_hold",  32'(b3.out),       32'd9);

    check("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
